// File: rtl/mips_pkg.sv
// Shared encodings, CP0 register map and system addresses for the mips core.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC     = 32'h0000_3000;
    localparam word_t HANDLER_PC   = 32'h0000_4180;
    localparam word_t INT_ACK_ADDR = 32'h0000_7F20;
    localparam word_t RAM_LIMIT    = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ERET = 6'h18;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] CP0_RS_MF = 5'h00;
    localparam logic [4:0] CP0_RS_MT = 5'h04;
    localparam logic [4:0] CP0_RS_CO = 5'h10;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;
    localparam int CAUSE_BD  = 31;
    localparam int CAUSE_IP2 = 12;
    localparam int IM_HW_IRQ = 2;

    function automatic word_t sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_cp0.sv
// Minimal coprocessor 0: SR/Cause/EPC, interrupt request and exception entry/return.
module mips_cp0
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        eret_i,
    output logic [31:0] rdata_o,
    output logic [31:0] epc_o,
    output logic        int_req_o
);
    logic [5:0]  im_q;
    logic        exl_q, ie_q, bd_q, ip2_q;
    logic [31:0] epc_q;

    assign int_req_o = interrupt_i & ie_q & ~exl_q & im_q[IM_HW_IRQ];
    assign epc_o     = epc_q;

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CP0_SR: begin
                rdata_o[SR_IM_HI:SR_IM_LO] = im_q;
                rdata_o[SR_EXL]            = exl_q;
                rdata_o[SR_IE]             = ie_q;
            end
            CP0_CAUSE: begin
                rdata_o[CAUSE_BD]  = bd_q;
                rdata_o[CAUSE_IP2] = ip2_q;
            end
            CP0_EPC: rdata_o = epc_q;
            default: rdata_o = '0;
        endcase
    end

    // Interrupt entry outranks eret and mtc0 because the instruction is squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip2_q <= 1'b0;
            epc_q <= '0;
        end else begin
            ip2_q <= interrupt_i;
            if (int_req_o) begin
                epc_q <= in_delay_slot_i ? pc_i - 32'd4 : pc_i;
                bd_q  <= in_delay_slot_i;
                exl_q <= 1'b1;
            end else if (eret_i) begin
                exl_q <= 1'b0;
            end else if (we_i) begin
                if (addr_i == CP0_SR) begin
                    im_q  <= wdata_i[SR_IM_HI:SR_IM_LO];
                    exl_q <= wdata_i[SR_EXL];
                    ie_q  <= wdata_i[SR_IE];
                end else if (addr_i == CP0_EPC) begin
                    epc_q <= wdata_i;
                end
            end
        end
    end
endmodule

// File: rtl/mips.sv
// Single-cycle MIPS-subset core with delayed branches, one hardware interrupt and CP0.
module mips
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_int_addr,
    output logic [3:0]  m_int_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic        ds_q, ds_d;
    logic [31:0] gpr_q [1:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    assign op    = i_inst_rdata[31:26];
    assign rs    = i_inst_rdata[25:21];
    assign rt    = i_inst_rdata[20:16];
    assign rd    = i_inst_rdata[15:11];
    assign shamt = i_inst_rdata[10:6];
    assign funct = i_inst_rdata[5:0];
    assign imm   = i_inst_rdata[15:0];

    logic [31:0] rs_val, rt_val, imm_sext, pc_plus4, mem_addr;
    logic [7:0]  lane_byte;
    assign rs_val    = (rs == 5'd0) ? 32'd0 : gpr_q[rs];
    assign rt_val    = (rt == 5'd0) ? 32'd0 : gpr_q[rt];
    assign imm_sext  = sext16(imm);
    assign pc_plus4  = pc_q + 32'd4;
    assign mem_addr  = rs_val + imm_sext;
    assign lane_byte = m_data_rdata[{mem_addr[1:0], 3'b000} +: 8];

    logic        wb_en, is_branch, taken, store, cp0_we, eret, int_req;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, target, store_data, cp0_rdata, epc;
    logic [3:0]  store_be;

    always_comb begin
        wb_en      = 1'b0;
        wb_addr    = rt;
        wb_data    = '0;
        is_branch  = 1'b0;
        taken      = 1'b0;
        target     = '0;
        store      = 1'b0;
        store_be   = 4'b0000;
        store_data = rt_val;
        cp0_we     = 1'b0;
        eret       = 1'b0;
        case (op)
            OP_RTYPE: begin
                wb_en   = 1'b1;
                wb_addr = rd;
                case (funct)
                    FN_ADDU: wb_data = rs_val + rt_val;
                    FN_SUBU: wb_data = rs_val - rt_val;
                    FN_AND:  wb_data = rs_val & rt_val;
                    FN_OR:   wb_data = rs_val | rt_val;
                    FN_SLT:  wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL:  wb_data = rt_val << shamt;
                    FN_JR: begin
                        wb_en     = 1'b0;
                        is_branch = 1'b1;
                        taken     = 1'b1;
                        target    = rs_val;
                    end
                    default: wb_en = 1'b0;
                endcase
            end
            OP_ORI:   begin wb_en = 1'b1; wb_data = rs_val | {16'd0, imm}; end
            OP_ADDIU: begin wb_en = 1'b1; wb_data = rs_val + imm_sext; end
            OP_LUI:   begin wb_en = 1'b1; wb_data = {imm, 16'd0}; end
            OP_LW:    begin wb_en = 1'b1; wb_data = m_data_rdata; end
            OP_LB:    begin wb_en = 1'b1; wb_data = {{24{lane_byte[7]}}, lane_byte}; end
            OP_SW:    begin store = 1'b1; store_be = 4'b1111; end
            OP_SB: begin
                store      = 1'b1;
                store_be   = 4'b0001 << mem_addr[1:0];
                store_data = {4{rt_val[7:0]}};
            end
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                taken     = (rs_val == rt_val) ^ (op == OP_BNE);
                target    = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OP_J, OP_JAL: begin
                is_branch = 1'b1;
                taken     = 1'b1;
                target    = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};
                if (op == OP_JAL) begin
                    wb_en   = 1'b1;
                    wb_addr = 5'd31;
                    wb_data = pc_q + 32'd8;
                end
            end
            OP_COP0: begin
                if (rs == CP0_RS_MF) begin
                    wb_en   = 1'b1;
                    wb_data = cp0_rdata;
                end else if (rs == CP0_RS_MT) begin
                    cp0_we = 1'b1;
                end else if (rs == CP0_RS_CO && funct == FN_ERET) begin
                    eret = 1'b1;
                end
            end
            default: ;
        endcase
    end

    mips_cp0 u_cp0 (
        .clk             (clk),
        .reset           (reset),
        .interrupt_i     (interrupt),
        .pc_i            (pc_q),
        .in_delay_slot_i (ds_q),
        .we_i            (cp0_we),
        .addr_i          (rd),
        .wdata_i         (rt_val),
        .eret_i          (eret),
        .rdata_o         (cp0_rdata),
        .epc_o           (epc),
        .int_req_o       (int_req)
    );

    logic store_ok, ram_hit, ack_hit;
    assign store_ok = store & ~int_req;
    assign ram_hit  = mem_addr < RAM_LIMIT;
    assign ack_hit  = mem_addr[31:2] == INT_ACK_ADDR[31:2];

    assign macroscopic_pc = pc_q;
    assign i_inst_addr    = pc_q;
    assign m_inst_addr    = pc_q;
    assign w_inst_addr    = pc_q;
    assign m_data_addr    = mem_addr;
    assign m_int_addr     = mem_addr;
    assign m_data_wdata   = store_data;
    assign m_data_byteen  = (store_ok && ram_hit) ? store_be : 4'b0000;
    assign m_int_byteen   = (store_ok && ack_hit) ? store_be : 4'b0000;
    assign w_grf_we       = wb_en & ~int_req;
    assign w_grf_addr     = wb_addr;
    assign w_grf_wdata    = wb_data;

    // Every branch opens a delay slot; an untaken one resumes at PC+8 after it.
    always_comb begin
        pc_d  = ds_q ? npc_q : pc_plus4;
        npc_d = npc_q;
        ds_d  = 1'b0;
        if (int_req) begin
            pc_d = HANDLER_PC;
        end else if (eret) begin
            pc_d = epc;
        end else if (is_branch) begin
            npc_d = taken ? target : pc_q + 32'd8;
            ds_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= '0;
            ds_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
            ds_q  <= ds_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) gpr_q[i] <= '0;
        end else if (w_grf_we && w_grf_addr != 5'd0) begin
            gpr_q[w_grf_addr] <= w_grf_wdata;
        end
    end
endmodule

// File: tb/tb_mips.sv
// Random-program bench for mips: an ISA-level model predicts each cycle's trace into a scoreboard.
module tb_mips;
    localparam int NCYC     = 700;
    localparam int BODY_END = 336;
    localparam int HND_IDX  = 1120;

    logic        clk = 1'b0, reset = 1'b1, interrupt = 1'b0;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
    logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]  m_data_byteen, m_int_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;

    always #5 clk = ~clk;

    mips dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
        .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
    );

    logic [31:0] rom [0:2047];
    logic [31:0] ram [0:255];

    function automatic logic [31:0] rom_fetch(input logic [31:0] a);
        if (a >= 32'h3000 && a < 32'h5000) return rom[(a - 32'h3000) >> 2];
        return 32'h0;
    endfunction

    always_comb i_inst_rdata = rom_fetch(i_inst_addr);
    always_comb m_data_rdata = (m_data_addr < 32'h400) ? ram[m_data_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 4; b++)
                if (m_data_byteen[b]) ram[m_data_addr[9:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] pc;
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  dbe, ibe;
        logic [31:0] maddr, mwdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, n_txn = 0;

    // Architectural state of the reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [256];
    logic [31:0] m_pc, m_npc, m_epc;
    bit          m_ds, m_exl, m_ie, m_bd, m_ip2;
    logic [5:0]  m_im;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (pc model %h)", name, act, want, m_pc);
        end
    endtask

    function automatic logic [31:0] cp0_read(input logic [4:0] r);
        logic [31:0] v = 32'h0;
        if (r == 5'd12) begin v[15:10] = m_im; v[1] = m_exl; v[0] = m_ie; end
        else if (r == 5'd13) begin v[31] = m_bd; v[12] = m_ip2; end
        else if (r == 5'd14) v = m_epc;
        return v;
    endfunction

    function automatic logic [31:0] load_word(input logic [31:0] a);
        return (a < 32'h400) ? m_mem[a[9:2]] : 32'h0;
    endfunction

    task automatic model_step(input logic [31:0] ins, input bit intr, output exp_t e);
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [4:0]  rs = ins[25:21], rt = ins[20:16], rd = ins[15:11], sh = ins[10:6];
        logic [31:0] rsv = m_regs[rs], rtv = m_regs[rt];
        logic [31:0] simm = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] addr = rsv + simm;
        logic [31:0] pc4 = m_pc + 32'd4;
        logic [31:0] seq = m_ds ? m_npc : pc4;
        logic [31:0] wval = 0, tgt = 0, lw_v = 0, new_npc;
        logic [4:0]  wa = rt;
        logic [3:0]  be = 0;
        bit wr = 0, br = 0, tk = 0, er = 0;
        e = '{pc: m_pc, we: 0, waddr: 0, wdata: 0, dbe: 0, ibe: 0, maddr: 0, mwdata: 0};
        if (intr && m_ie && !m_exl && m_im[2]) begin
            m_epc = m_ds ? m_pc - 32'd4 : m_pc;
            m_bd  = m_ds;
            m_exl = 1;
            m_pc  = 32'h4180;
            m_ds  = 0;
        end else begin
            case (op)
                6'h00: begin
                    wr = 1; wa = rd;
                    case (fn)
                        6'h21: wval = rsv + rtv;
                        6'h23: wval = rsv - rtv;
                        6'h24: wval = rsv & rtv;
                        6'h25: wval = rsv | rtv;
                        6'h2A: wval = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                        6'h00: wval = rtv << sh;
                        6'h08: begin wr = 0; br = 1; tk = 1; tgt = rsv; end
                        default: wr = 0;
                    endcase
                end
                6'h0D: begin wr = 1; wval = rsv | {16'h0, ins[15:0]}; end
                6'h09: begin wr = 1; wval = rsv + simm; end
                6'h0F: begin wr = 1; wval = {ins[15:0], 16'h0}; end
                6'h23: begin wr = 1; wval = load_word(addr); end
                6'h20: begin
                    wr = 1;
                    lw_v = load_word(addr) >> (8 * addr[1:0]);
                    wval = {{24{lw_v[7]}}, lw_v[7:0]};
                end
                6'h2B: begin be = 4'hF; e.mwdata = rtv; end
                6'h28: begin be = 4'h1 << addr[1:0]; e.mwdata = {4{rtv[7:0]}}; end
                6'h04: begin br = 1; tk = (rsv == rtv); tgt = pc4 + (simm << 2); end
                6'h05: begin br = 1; tk = (rsv != rtv); tgt = pc4 + (simm << 2); end
                6'h02: begin br = 1; tk = 1; tgt = {pc4[31:28], ins[25:0], 2'b00}; end
                6'h03: begin
                    br = 1; tk = 1; tgt = {pc4[31:28], ins[25:0], 2'b00};
                    wr = 1; wa = 5'd31; wval = m_pc + 32'd8;
                end
                6'h10: begin
                    if (rs == 5'd0) begin wr = 1; wval = cp0_read(rd); end
                    else if (rs == 5'd4) begin
                        if (rd == 5'd12) begin m_im = rtv[15:10]; m_exl = rtv[1]; m_ie = rtv[0]; end
                        else if (rd == 5'd14) m_epc = rtv;
                    end else if (ins == 32'h4200_0018) er = 1;
                end
                default: ;
            endcase
            if (be != 0) begin
                e.maddr = addr;
                if (addr < 32'h3000) begin
                    e.dbe = be;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_mem[addr[9:2]][8*b +: 8] = e.mwdata[8*b +: 8];
                end else if (addr[31:2] == 30'(32'h7F20 >> 2)) begin
                    e.ibe = be;
                end
            end
            if (wr) begin
                e.we = 1; e.waddr = wa; e.wdata = wval;
                if (wa != 0) m_regs[wa] = wval;
            end
            if (er) begin
                m_pc = m_epc; m_exl = 0; m_ds = 0;
            end else if (br) begin
                new_npc = tk ? tgt : m_pc + 32'd8;
                m_pc = seq; m_npc = new_npc; m_ds = 1;
            end else begin
                m_pc = seq; m_ds = 0;
            end
        end
        m_ip2 = intr;
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input logic [31:0] t);
        return {6'(op), t[27:2]};
    endfunction
    function automatic logic [31:0] enc_c0(input int sub, input int rt, input int rd);
        return {6'h10, 5'(sub), 5'(rt), 5'(rd), 11'd0};
    endfunction
    function automatic logic [31:0] idx_addr(input int i);
        return 32'h3000 + 32'(4 * i);
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("pc", macroscopic_pc, mon_e.pc);
            check("i_inst_addr", i_inst_addr, mon_e.pc);
            check("w_inst_addr", w_inst_addr, mon_e.pc);
            check("m_inst_addr", m_inst_addr, mon_e.pc);
            check("w_grf_we", 32'(w_grf_we), 32'(mon_e.we));
            if (mon_e.we) begin
                check("w_grf_addr", 32'(w_grf_addr), 32'(mon_e.waddr));
                check("w_grf_wdata", w_grf_wdata, mon_e.wdata);
            end
            check("m_data_byteen", 32'(m_data_byteen), 32'(mon_e.dbe));
            check("m_int_byteen", 32'(m_int_byteen), 32'(mon_e.ibe));
            if (mon_e.dbe != 0 || mon_e.ibe != 0) begin
                check("m_data_addr", m_data_addr, mon_e.maddr);
                check("m_int_addr", m_int_addr, mon_e.maddr);
                check("m_data_wdata", m_data_wdata, mon_e.mwdata);
            end
            $display("txn %0d pc=%h irq=%0b we=%0b a=%0d d=%h dbe=%b ibe=%b",
                     n_txn, macroscopic_pc, interrupt, w_grf_we, w_grf_addr, w_grf_wdata,
                     m_data_byteen, m_int_byteen);
            n_txn++;
        end
    end

    initial begin
        static int i = 16;
        static bit prev_br = 0;
        static bit irq_pending = 0;
        static int alu_fn[6] = '{32'h21, 32'h23, 32'h24, 32'h25, 32'h2A, 32'h00};
        exp_t e;
        int k, t;

        for (int a = 0; a < 2048; a++) rom[a] = 32'h0;
        for (int a = 0; a < 256; a++) begin ram[a] = 32'h0; m_mem[a] = 32'h0; end

        rom[0]  = enc_i(6'h0D, 0, 1, 16'h1234);
        rom[1]  = enc_i(6'h0F, 0, 1, 16'h1234);
        rom[2]  = enc_i(6'h0D, 1, 1, 16'h5678);
        rom[3]  = enc_i(6'h28, 0, 1, 1);
        rom[4]  = enc_i(6'h20, 0, 2, 1);
        rom[5]  = enc_i(6'h04, 0, 0, 2);
        rom[6]  = enc_i(6'h0D, 0, 3, 16'h0055);
        rom[7]  = enc_i(6'h0D, 0, 3, 16'h0066);
        rom[8]  = enc_i(6'h0D, 0, 6, 16'h1401);
        rom[9]  = enc_c0(4, 6, 12);
        rom[10] = enc_j(6'h03, idx_addr(14));
        rom[11] = 32'h0;
        rom[12] = enc_j(6'h02, idx_addr(16));
        rom[13] = 32'h0;
        rom[14] = enc_r(6'h08, 31, 0, 0, 0);
        rom[15] = 32'h0;

        // Random body: forward-only branches, never a branch in a slot, none near the end
        while (i < BODY_END) begin
            k = $urandom_range(0, 15);
            if ((prev_br || i >= BODY_END - 6) && k >= 11) k = $urandom_range(0, 9);
            if (k == 10 && i + 1 >= BODY_END) k = 4;
            prev_br = (k >= 11);
            case (k)
                0, 1, 2, 3: begin
                    t = alu_fn[$urandom_range(0, 5)];
                    rom[i] = enc_r(t, $urandom_range(0, 7), $urandom_range(0, 7),
                                   $urandom_range(0, 7), $urandom_range(0, 31));
                end
                4: begin
                    t = $urandom_range(0, 2);
                    rom[i] = enc_i(t == 0 ? 6'h0D : (t == 1 ? 6'h09 : 6'h0F), $urandom_range(0, 7),
                                   $urandom_range(1, 7), $urandom_range(0, 65535));
                end
                5: rom[i] = $urandom_range(0, 1) ? enc_i(6'h23, 0, $urandom_range(1, 7), 4 * $urandom_range(0, 63))
                                                : enc_i(6'h20, 0, $urandom_range(1, 7), $urandom_range(0, 255));
                6: rom[i] = $urandom_range(0, 1) ? enc_i(6'h2B, 0, $urandom_range(0, 7), 4 * $urandom_range(0, 63))
                                                : enc_i(6'h28, 0, $urandom_range(0, 7), $urandom_range(0, 255));
                7: rom[i] = enc_c0(0, $urandom_range(1, 7), $urandom_range(12, 14));
                8: rom[i] = enc_c0(4, $urandom_range(0, 7), $urandom_range(13, 14));
                9: rom[i] = enc_i(6'h2B, 0, $urandom_range(0, 7), $urandom_range(0, 1) ? 16'h7F20 : 16'h5000);
                10: begin
                    t = $urandom_range(0, 2);
                    rom[i] = enc_i(6'h0D, 0, 6, t == 0 ? 16'h1401 : (t == 1 ? 16'h1400 : 16'h0401));
                    i++;
                    rom[i] = enc_c0(4, 6, 12);
                end
                14: rom[i] = enc_j(6'h03, idx_addr(i + 1 + $urandom_range(1, 3)));
                default: rom[i] = $urandom_range(0, 3) == 0 ? enc_i(6'h04, 0, 0, $urandom_range(1, 4))
                                  : enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, $urandom_range(0, 3),
                                          $urandom_range(0, 3), $urandom_range(1, 4));
            endcase
            i++;
        end
        rom[BODY_END]     = enc_j(6'h02, idx_addr(BODY_END));
        rom[BODY_END + 1] = 32'h0;

        rom[HND_IDX]     = enc_i(6'h2B, 0, 1, 16'h7F20);
        rom[HND_IDX + 1] = enc_c0(0, 5, 14);
        rom[HND_IDX + 2] = enc_c0(0, 4, 13);
        rom[HND_IDX + 3] = 32'h4200_0018;

        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc = 32'h3000; m_npc = 0; m_epc = 0; m_ds = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip2 = 0; m_im = 0;

        repeat (2) @(negedge clk);
        check("reset_pc", macroscopic_pc, 32'h3000);
        check("reset_dbe", 32'(m_data_byteen), 32'h0);
        check("reset_ibe", 32'(m_int_byteen), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (!irq_pending && $urandom_range(0, 24) == 0) irq_pending = 1;
            interrupt = irq_pending;
            model_step(rom_fetch(m_pc), irq_pending, e);
            exp_q.push_back(e);
            if (e.ibe != 0) irq_pending = 0;
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips.md
Name: mips

Overview:
- Single-cycle MIPS-subset CPU core with one external hardware interrupt line and a minimal CP0 (SR, Cause, EPC).
- Fetches from an external combinational instruction ROM and accesses an external combinational-read, clocked-write data RAM.
- Exposes an interrupt-acknowledge store port and register-writeback trace signals for the system bench.
- Every instruction fetches, executes and commits in one cycle.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset.
- HANDLER_PC, 32'h0000_4180, interrupt entry address.
- INT_ACK_ADDR, 32'h0000_7F20, word address of the interrupt-acknowledge register.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- interrupt  in  1  level-sensitive external interrupt (HW IP[2]).
- macroscopic_pc  out  32  PC of the instruction executing this cycle.
- i_inst_addr  out  32  fetch address (equals PC).
- i_inst_rdata  in  32  instruction word, combinational.
- m_data_addr  out  32  byte address of the load/store.
- m_data_rdata  in  32  aligned word read, combinational.
- m_data_wdata  out  32  store data, lane-shifted.
- m_data_byteen  out  4  store byte enables for RAM; 0 when there is no RAM store.
- m_int_addr  out  32  same as m_data_addr.
- m_int_byteen  out  4  store byte enables when the address hits the ack word.
- m_inst_addr  out  32  PC of the instruction making the memory access.
- w_grf_we  out  1  register-file write enable.
- w_grf_addr  out  5  destination register.
- w_grf_wdata  out  32  write data.
- w_inst_addr  out  32  PC of the writing instruction.

Behaviour:
- Reset: PC=RESET_PC, all 32 GPRs=0, SR=Cause=EPC=0, delay-slot flag=0. Outputs follow combinationally from this state.
- ISA: addu, subu, and, or, slt, sll, jr (R-type); ori, addiu, lui, lw, sw, lb, sb, beq, bne, j, jal, mfc0, mtc0, eret.
- Undecoded opcodes execute as nop. No overflow or address exceptions.
- $0 is always read as 0; writes to $0 are ignored, but w_grf_we may still be 1 for them.
- Branches and jumps are delayed by one slot. A taken branch or jump loads a nextPC register used after the slot instruction.
  - beq/bne target = PC+4+(sext(imm)<<2).
  - j/jal target = {PC+4[31:28], idx, 2'b00}.
  - jal writes PC+8 to $31.
- Loads:
  - lw reads m_data_rdata.
  - lb sign-extends the byte selected by addr[1:0], little-endian: lane 0 = bits 7:0.
- Stores:
  - sw: byteen=4'b1111, wdata=rt.
  - sb: byteen=1<<addr[1:0], wdata={4{rt[7:0]}}.
- Store routing:
  - Address 0x0000..0x2FFF: drive m_data_byteen, m_int_byteen=0.
  - Word address == INT_ACK_ADDR: drive m_int_byteen, m_data_byteen=0.
  - Any other address: both zero.
- CP0 registers (mfc0/mtc0 select by rd):
  - 12 SR: IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - 13 Cause: BD=[31], IP=[15:10] (IP[2]=bit 12 mirrors interrupt every cycle), ExcCode=[6:2]; read-only to mtc0.
  - 14 EPC: read/write.
- Interrupt take condition, evaluated combinationally each cycle: interrupt & SR.IE & ~SR.EXL & SR.IM[2].
- When the interrupt is taken, the current instruction is squashed: w_grf_we=0, both byteens=0, no CP0 write. At posedge:
  - EPC = in_delay_slot ? PC-4 : PC.
  - Cause.BD = in_delay_slot; ExcCode=0.
  - EXL=1.
  - PC=HANDLER_PC; pending branch cancelled.
- eret: PC=EPC, EXL=0, no delay slot, no writeback.
- mtc0 SR in the same cycle as an interrupt is squashed (the interrupt wins).
- Trace: w_inst_addr = m_inst_addr = macroscopic_pc = PC.

Decomposition:
- Shared package holds:
  - opcode/funct constants;
  - CP0 register numbers 12/13/14;
  - SR/Cause bit positions;
  - RESET_PC, HANDLER_PC, INT_ACK_ADDR.
- One sub-module, mips_cp0: SR/Cause/EPC, interrupt request logic, EPC/EXL update, eret.
- Decode, ALU and GRF stay inline in mips.

Test Plan:
- Reset, then "ori $1,$0,0x1234" at 0x3000 -> w_grf_we=1, addr=1, wdata=0x00001234, w_inst_addr=0x3000.
- "sb $1,1($0)" with $1=0x12345678 -> m_data_byteen=4'b0010, wdata=0x78787878, addr=0x1. A following lb from the same address -> 0x00000078.
- "beq $0,$0,+2" at 0x3008 -> the slot at 0x300C executes and commits, next PC=0x3014. Likewise "jal" at 0x3020 -> $31=0x3028.
- SR=0x1401 set via mtc0, interrupt asserted while PC=0x3010 -> instruction at 0x3010 is squashed, next PC=0x4180, EPC=0x3010, Cause[12]=1, SR.EXL=1.
- Handler "sw $x,0x7F20($0)" -> m_int_byteen=4'b1111, m_int_addr=0x7F20, m_data_byteen=0. Then eret -> PC=0x3010, EXL=0, and 0x3010 re-executes.
- Interrupt asserted while SR.IE=0, or while a delay slot executes with IE=1 -> no entry in the first case; in the second, EPC=branch PC and Cause.BD=1.
